ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the core's word-addressed instruction memory, which has a combinational read.
- Owns the fetch PC and drives the memory address.
- Captures each returned instruction with its PC into a small prefetch FIFO.
- Presents entries to decode over a valid/ready handshake.
- Handles redirects (branch/jump), halt and fetch faults.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
MEM_SIZE, 1024, instruction memory depth in words; legal fetch PCs are 0 to MEM_SIZE*4-4
RESET_PC, 32'h0, fetch PC loaded on reset
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
imem_addr_o  output  DATA_WIDTH  byte address to instruction memory (equals fetch PC)
imem_instr_i  input  DATA_WIDTH  instruction returned combinationally for imem_addr_o
instr_o  output  DATA_WIDTH  FIFO head instruction
pc_o  output  DATA_WIDTH  FIFO head PC
instr_valid_o  output  1  FIFO head valid
instr_ready_i  input  1  decode accepts head
redirect_i  input  1  one-cycle redirect request
redirect_pc_i  input  DATA_WIDTH  redirect target
halt_i  input  1  suspend new fetches (level)
fetch_err_o  output  1  sticky fault: misaligned or out-of-range PC

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - fetch_pc = RESET_PC; state = RUN; FIFO empty.
  - instr_valid_o = 0; instr_o = 0; pc_o = 0; fetch_err_o = 0.
  - imem_addr_o = RESET_PC.
- imem_addr_o is combinational from fetch_pc.
- States:
  - RUN: fetch enabled.
  - HALT: no pushes; FIFO drains.
  - ERROR: no pushes; fetch_err_o = 1.
- Push condition, all required: state = RUN, halt_i = 0, redirect_i = 0, and FIFO not full or a pop occurs this cycle.
  - On push: enqueue {fetch_pc, imem_instr_i} and set fetch_pc += 4.
- Pop: instr_valid_o && instr_ready_i. The head advances at the clock edge.
- Full FIFO with simultaneous pop: push is allowed, giving full throughput of 1 instruction/cycle.
- Latency: the first instr_valid_o rises on the first clk edge after rst_n deasserts. Push-to-head latency is 1 cycle when the FIFO is empty.
- Redirect (redirect_i = 1) takes priority over push:
  - A pop in the same cycle still completes; decode has consumed that entry.
  - All remaining FIFO entries are flushed at the edge.
  - The instruction fetched that cycle is discarded.
  - fetch_pc = redirect_pc_i.
  - The next cycle fetches from the target, so valid is low for 1 cycle after the redirect.
- Misaligned redirect (redirect_pc_i[1:0] != 0):
  - Flush the FIFO and go to ERROR.
  - fetch_pc is still loaded with the target so the faulting PC is visible on imem_addr_o.
- Out of range: fetch_pc >= MEM_SIZE*4 while in RUN → ERROR.
  - Entries already in the FIFO still drain.
  - No entry is pushed for the bad PC.
  - Sequential fetch past the last word therefore faults; the PC never wraps.
- Leaving ERROR: only by reset or an aligned, in-range redirect, which clears fetch_err_o and goes to RUN (or HALT if halt_i = 1).
- halt_i = 1 in RUN → HALT; halt_i = 0 in HALT → RUN.
  - A redirect during HALT flushes the FIFO and updates fetch_pc; state stays HALT.
- Reset mid-operation: immediate, asynchronous return to reset values. Any in-flight FIFO content is lost.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds output ports fetch_cnt_o[31:0] and stall_cnt_o[31:0].
  - fetch_cnt_o counts pushes.
  - stall_cnt_o counts cycles with instr_valid_o = 1 and instr_ready_i = 0.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package ifetch_pkg:
  - fetch_entry_t struct {pc, instr}.
  - ifetch_state_e enum {RUN, HALT, ERROR}.
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h00000013.
- Sub-module ifetch_fifo: generic synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Same clk/rst_n convention.
  - Head is registered storage. Flush has priority over push in the same cycle.

Test Plan:
- Memory words 0..3 = 13,00100093,00200113,002081b3; ready = 1 → valid from cycle 1 after reset; pc_o = 0,4,8,C on consecutive cycles with matching instructions.
- ready = 0 for 5 cycles from reset → FIFO fills to 2; imem_addr_o holds at 8; then ready = 1 → pc_o = 0,4,8 in order, nothing lost or duplicated.
- redirect_i with target 0x10 while the FIFO holds PCs 4,8 → both flushed; valid low for 1 cycle; next pc_o = 0x10 with instruction 00312233.
- redirect target 0x6 → fetch_err_o = 1, valid low after drain; then redirect to 0x0 → fetch_err_o = 0 and fetch resumes at 0.
- MEM_SIZE = 8, free-run → last pc_o = 0x1C; fetch_err_o rises when fetch_pc = 0x20; no entry is ever pushed for 0x20.
- halt_i = 1 at PC 8 → FIFO drains, no pushes; halt_i = 0 → next pc_o continues from the halted PC. Also assert rst_n = 0 mid-stream → outputs return to reset values immediately.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch sequencer
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {RUN, HALT, ERROR} ifetch_state_e;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
// Ports: clk, rst_n (async, active-low), i_push/i_din enqueue, i_pop dequeue,
// i_flush empties (wins over push), o_full, o_empty, o_head (registered storage).
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer with prefetch FIFO and valid/ready to decode.
// Ports: clk, rst_n (async, active-low); imem_addr_o/imem_instr_i to combinational imem;
// instr_o/pc_o/instr_valid_o/instr_ready_i to decode; redirect_i/redirect_pc_i, halt_i;
// fetch_err_o sticky fault. With IFETCH_PERF_EN defined, adds fetch_cnt_o and stall_cnt_o.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  fetch_err_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);
  localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEM_SIZE * INSTR_BYTES);
  ifetch_state_e r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_pc, w_pc_n;
  logic w_push, w_pop, w_full, w_empty, w_pc_ok, w_bad_tgt;
  fetch_entry_t w_head, w_din;
  assign w_pc_ok = r_pc < PC_LIMIT;
  assign w_bad_tgt = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i >= PC_LIMIT);
  assign w_pop = !w_empty && instr_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_push = (r_state == RUN) && !halt_i && !redirect_i && w_pc_ok && (!w_full || w_pop);
  assign w_din = '{pc: r_pc, instr: imem_instr_i};
  assign imem_addr_o = r_pc;
  assign instr_valid_o = !w_empty;
  assign instr_o = w_empty ? '0 : w_head.instr;
  assign pc_o = w_empty ? '0 : w_head.pc;
  assign fetch_err_o = r_state == ERROR;
  always_comb begin
    w_state_n = r_state;
    w_pc_n = r_pc;
    w_pc_n = redirect_i ? redirect_pc_i : w_push ? r_pc + DATA_WIDTH'(INSTR_BYTES) : r_pc;
    w_state_n = redirect_i ? (w_bad_tgt ? ERROR : halt_i ? HALT : RUN)
              : r_state == ERROR ? ERROR
              : (r_state == RUN && !w_pc_ok) ? ERROR
              : halt_i ? HALT : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_pc <= w_pc_n;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;
  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 32'(w_push);
      r_stall_cnt <= r_stall_cnt + 32'(instr_valid_o && !instr_ready_i);
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and random checks of ifetch_ctrl against a queue-based model
module tb_ifetch_ctrl;
  localparam int MEM = 16;
  localparam int DEPTH = 2;
  localparam logic [31:0] LIMIT = 32'(MEM * 4);
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] imem_addr_o, imem_instr_i, instr_o, pc_o, redirect_pc_i;
  logic instr_valid_o, fetch_err_o;
  logic instr_ready_i = 1'b0, redirect_i = 1'b0, halt_i = 1'b0;
  logic [31:0] mem [64];
  logic [31:0] plan [4];
  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit m_halt, m_fault;
  int n_chk = 0, n_err = 0;

  ifetch_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(MEM), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;
  assign imem_instr_i = mem[imem_addr_o[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: decode pops the oldest entry, redirect clears everything, otherwise
  // one in-range word is fetched per cycle while there is room.
  task automatic model_edge();
    if (q.size() > 0 && instr_ready_i) void'(q.pop_front());
    if (redirect_i) begin
      q.delete();
      m_pc = redirect_pc_i;
      m_fault = (redirect_pc_i % 4 != 0) || (redirect_pc_i >= LIMIT);
      m_halt = halt_i;
    end else if (!m_fault) begin
      if (m_halt) m_halt = halt_i;
      else if (m_pc >= LIMIT) m_fault = 1'b1;
      else if (halt_i) m_halt = 1'b1;
      else if (q.size() < DEPTH) begin
        q.push_back({m_pc, mem[m_pc[7:2]]});
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(instr_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("pc_o", pc_o, q[0][63:32]);
      chk("instr_o", instr_o, q[0][31:0]);
    end
    chk("fetch_err", 32'(fetch_err_o), 32'(m_fault));
    chk("imem_addr", imem_addr_o, m_pc);
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hlt);
    instr_ready_i = rdy;
    redirect_i = rd;
    redirect_pc_i = rpc;
    halt_i = hlt;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_err", 32'(fetch_err_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    q.delete();
    m_pc = 32'h0;
    m_halt = 1'b0;
    m_fault = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    halt_i = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit hl;
    logic [31:0] rpc;
    int r;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0020_81b3;
    mem[4] = 32'h0031_2233;
    for (int i = 0; i < 4; i++) plan[i] = mem[i];
    redirect_pc_i = 32'h0;
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("t1_pc", pc_o, 32'(i * 4));
      chk("t1_instr", instr_o, plan[i]);
    end
    do_reset();
    repeat (5) step(0, 0, 0, 0);
    chk("t2_addr_hold", imem_addr_o, 32'h8);
    chk("t2_pc0", pc_o, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0);
      chk("t2_pc", pc_o, 32'(i * 4));
    end
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_head4", pc_o, 32'h4);
    step(0, 1, 32'h10, 0);
    chk("t3_flush_valid", 32'(instr_valid_o), 32'd0);
    step(1, 0, 0, 0);
    chk("t3_tgt_pc", pc_o, 32'h10);
    chk("t3_tgt_instr", instr_o, 32'h0031_2233);
    step(0, 1, 32'h6, 0);
    chk("t4_err", 32'(fetch_err_o), 32'd1);
    chk("t4_addr", imem_addr_o, 32'h6);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 32'h0, 0);
    chk("t4_err_clr", 32'(fetch_err_o), 32'd0);
    step(1, 0, 0, 0);
    chk("t4_resume", pc_o, 32'h0);
    step(1, 1, LIMIT - 8, 0);
    step(1, 0, 0, 0);
    chk("t5_pc_m2", pc_o, LIMIT - 8);
    step(1, 0, 0, 0);
    chk("t5_pc_last", pc_o, LIMIT - 4);
    step(1, 0, 0, 0);
    chk("t5_err", 32'(fetch_err_o), 32'd1);
    chk("t5_no_push", 32'(instr_valid_o), 32'd0);
    step(1, 0, 0, 0);
    step(1, 1, 32'h0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t6_drained", 32'(instr_valid_o), 32'd0);
    chk("t6_addr", imem_addr_o, 32'h8);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_resume", pc_o, 32'h8);
    hl = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) hl = !hl;
      r = $urandom_range(0, 9);
      rpc = r < 7 ? {26'd0, 4'($urandom_range(0, 15)), 2'b00}
          : r == 7 ? {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))}
          : r == 8 ? LIMIT - 4 * 32'($urandom_range(1, 3))
          : LIMIT + 4 * 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rpc, hl);
      if (n == 300) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
